// File: rtl/pipe_defs.sv
// Shared pipeline definitions.
// Holds the reset PC, the bubble encoding, the fetch-stage state encoding and
// the jumpType codes that the control unit and the MEM stage agree on.
package pipe_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Fetch-stage sequencing: one boot cycle after reset, then run forever.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } ifState_e;

    // Redirect kinds resolved in MEM; the fetch stage only sees the taken flag.
    typedef enum logic [1:0] {
        JT_NONE   = 2'd0,
        JT_BRANCH = 2'd1,
        JT_JUMP   = 2'd2,
        JT_JREG   = 2'd3
    } jumpType_e;

endpackage

// File: rtl/pipe_ifid_reg.sv
// Generic pipeline register carrying an instruction word, its pc+4 and a
// valid flag. Used between IF and ID, and later between ID and EX.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (bubble with pc4 cleared)
//   en_i       load inst_i/pc4_i and mark the slot valid
//   bubble_i   load NOP_INST, clear valid, keep pc4 (wins over en_i)
//   inst_i     incoming instruction word
//   pc4_i      incoming pc+4
//   inst_o     registered instruction
//   pc4_o      registered pc+4
//   valid_o    slot holds a real instruction
module pipe_ifid_reg
    import pipe_defs::*;
#(
    parameter logic [31:0] NOP_INST = pipe_defs::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        bubble_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instQ;
    logic [31:0] pc4Q;
    logic        validQ;

    // A bubble must override a normal load so a squash always turns the slot
    // into a harmless no-op; pc4 is left alone because nothing downstream
    // consumes it while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            instQ  <= NOP_INST;
            pc4Q   <= 32'd0;
            validQ <= 1'b0;
        end else if (bubble_i) begin
            instQ  <= NOP_INST;
            validQ <= 1'b0;
        end else if (en_i) begin
            instQ  <= inst_i;
            pc4Q   <= pc4_i;
            validQ <= 1'b1;
        end
    end

    assign inst_o  = instQ;
    assign pc4_o   = pc4Q;
    assign valid_o = validQ;

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with its IF/ID register.
// Owns the PC, drives the instruction-memory address straight from the PC
// register, honours the control unit's stall enables and applies MEM-stage
// redirects by squashing the wrong-path slot.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   IFwip        PC write enable (0 = load stall)
//   IDwir        IF/ID write enable (0 = hold)
//   IFwillJump   MEM-stage redirect taken
//   MEMtarget    redirect target
//   imem_addr    instruction memory address (registered pc)
//   imem_data    instruction word read combinationally at imem_addr
//   IDinst/IDpc4/IDvalid   IF/ID contents
//   fetch_cnt    saturating count of instructions accepted into IF/ID
//   squash_cnt   saturating count of valid slots squashed by a redirect
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = pipe_defs::RESET_PC,
    parameter logic [31:0] NOP_INST = pipe_defs::NOP_INST,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IFwip,
    input  logic             IDwir,
    input  logic             IFwillJump,
    input  logic [31:0]      MEMtarget,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      IDinst,
    output logic [31:0]      IDpc4,
    output logic             IDvalid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    import pipe_defs::*;

    ifState_e         state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pcPlus4;
    logic             ifidEn;
    logic             ifidBubble;
    logic             fetchInc;
    logic             squashInc;
    logic [CNT_W-1:0] fetch_q;
    logic [CNT_W-1:0] squash_q;

    // Wraps modulo 2^32 naturally at 32'hFFFF_FFFC.
    assign pcPlus4 = pc_q + 32'd4;

    // State, PC and counter registers. Reset beats everything, including a
    // redirect that happens to be pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            fetch_q  <= '0;
            squash_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetchInc && (fetch_q != '1)) begin
                fetch_q <= fetch_q + 1'b1;
            end
            if (squashInc && (squash_q != '1)) begin
                squash_q <= squash_q + 1'b1;
            end
        end
    end

    // Next-PC mux and IF/ID control. BOOT spends one cycle holding the reset
    // PC while IF/ID takes a bubble, ignoring any redirect. In RUN a redirect
    // outranks both stall enables; otherwise PC and IF/ID each follow their
    // own enable, so a lone IDwir=1 still accepts the word at the held PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifidEn     = 1'b0;
        ifidBubble = 1'b0;
        fetchInc   = 1'b0;
        squashInc  = 1'b0;
        case (state_q)
            BOOT: begin
                ifidBubble = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (IFwillJump) begin
                    pc_d       = MEMtarget;
                    ifidBubble = 1'b1;
                    squashInc  = IDvalid;
                end else begin
                    if (IFwip) begin
                        pc_d = pcPlus4;
                    end
                    if (IDwir) begin
                        ifidEn   = 1'b1;
                        fetchInc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    pipe_ifid_reg #(
        .NOP_INST(NOP_INST)
    ) uIfId (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ifidEn),
        .bubble_i(ifidBubble),
        .inst_i  (imem_data),
        .pc4_i   (pcPlus4),
        .inst_o  (IDinst),
        .pc4_o   (IDpc4),
        .valid_o (IDvalid)
    );

    assign imem_addr  = pc_q;
    assign fetch_cnt  = fetch_q;
    assign squash_cnt = squash_q;

endmodule
